// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals between the load/store units, the data-memory port 2 and the arbiter.
// The arbiter connects through the slave modport; the units and memory model use master.
interface mem_port_arbiter_if #(
  parameter int unsigned TagW = 4
);
  // Load unit request side
  logic            ld_req;
  logic [31:0]     ld_addr;
  logic [2:0]      ld_type;
  logic [TagW-1:0] ld_tag;
  // Store unit request side
  logic            st_req;
  logic [31:0]     st_addr;
  logic [31:0]     st_data;
  logic [2:0]      st_type;
  // Completion side
  logic            ld_done;
  logic [31:0]     ld_data;
  logic [TagW-1:0] ld_tag_out;
  logic            st_done;
  logic            err;
  logic            busy;
  // Memory port 2
  logic [31:0]     mem_addr2;
  logic [31:0]     mem_din2;
  logic            mem_read2;
  logic            mem_write2;
  logic            mem_sign;
  logic [1:0]      mem_size;
  logic [31:0]     mem_dout2;
  logic            mem_valid;

  modport slave (
    input  ld_req, ld_addr, ld_type, ld_tag,
    input  st_req, st_addr, st_data, st_type,
    input  mem_dout2, mem_valid,
    output ld_done, ld_data, ld_tag_out, st_done, err, busy,
    output mem_addr2, mem_din2, mem_read2, mem_write2, mem_sign, mem_size
  );

  modport master (
    output ld_req, ld_addr, ld_type, ld_tag,
    output st_req, st_addr, st_data, st_type,
    output mem_dout2, mem_valid,
    input  ld_done, ld_data, ld_tag_out, st_done, err, busy,
    input  mem_addr2, mem_din2, mem_read2, mem_write2, mem_sign, mem_size
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares data-memory port 2 between the load and store units. One transaction in flight:
// grant (round-robin on ties), one-cycle strobe, wait for the response or a timeout,
// then a one-cycle done pulse to the granted unit. All outputs are registered.
// TagW must match the TagW of the connected interface.
module mem_port_arbiter #(
  parameter int unsigned TagW    = 4,
  parameter int unsigned Timeout = 255  // WAIT cycles before abort; 0 disables
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam bit         TimeoutEn = (Timeout != 0);
  localparam logic [7:0] CntLast   = 8'(Timeout - 1);

  state_e          state_q;
  logic            last_st_q;  // 1: store holds the most recent grant
  logic            is_st_q;
  logic [7:0]      cnt_q;
  logic [TagW-1:0] tag_q;

  logic            ld_done_q, st_done_q, err_q, busy_q;
  logic            mem_read_q, mem_write_q, mem_sign_q;
  logic [1:0]      mem_size_q;
  logic [31:0]     mem_addr_q, mem_din_q, ld_data_q;
  logic [TagW-1:0] ld_tag_out_q;

  logic            grant_st;
  logic [2:0]      grant_type;
  logic            finish;

  // Store wins when it is the only requester, or on a tie when load was granted last.
  assign grant_st   = bus.st_req & (~bus.ld_req | ~last_st_q);
  assign grant_type = grant_st ? bus.st_type : bus.ld_type;
  // A response always beats a timeout that lands in the same cycle.
  assign finish     = bus.mem_valid | (TimeoutEn && (cnt_q == CntLast));

  // Transaction FSM together with its registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_st_q    <= 1'b1;
      is_st_q      <= 1'b0;
      cnt_q        <= '0;
      tag_q        <= '0;
      ld_done_q    <= 1'b0;
      st_done_q    <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_sign_q   <= 1'b0;
      mem_size_q   <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      ld_data_q    <= '0;
      ld_tag_out_q <= '0;
    end else begin
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.ld_req || bus.st_req) begin
            state_q     <= StIssue;
            busy_q      <= 1'b1;
            last_st_q   <= grant_st;
            is_st_q     <= grant_st;
            mem_read_q  <= ~grant_st;
            mem_write_q <= grant_st;
            mem_addr_q  <= grant_st ? bus.st_addr : bus.ld_addr;
            mem_din_q   <= grant_st ? bus.st_data : '0;
            mem_sign_q  <= grant_type[2];
            mem_size_q  <= grant_type[1:0];
            tag_q       <= bus.ld_tag;
          end
        end
        StIssue: begin
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
          cnt_q       <= '0;
          state_q     <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q + 8'd1;
          if (finish) begin
            state_q <= StResp;
            err_q   <= ~bus.mem_valid;
            if (is_st_q) begin
              st_done_q <= 1'b1;
            end else begin
              ld_done_q    <= 1'b1;
              ld_data_q    <= bus.mem_valid ? bus.mem_dout2 : '0;
              ld_tag_out_q <= tag_q;
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ld_done    = ld_done_q;
  assign bus.ld_data    = ld_data_q;
  assign bus.ld_tag_out = ld_tag_out_q;
  assign bus.st_done    = st_done_q;
  assign bus.err        = err_q;
  assign bus.busy       = busy_q;
  assign bus.mem_addr2  = mem_addr_q;
  assign bus.mem_din2   = mem_din_q;
  assign bus.mem_read2  = mem_read_q;
  assign bus.mem_write2 = mem_write_q;
  assign bus.mem_sign   = mem_sign_q;
  assign bus.mem_size   = mem_size_q;

endmodule
